// File: rtl/id_stage_pipe_if.sv
// Handshake and data bundle between IF, write-back, the ID stage and EX.
// Optional ID_HAZARD_CNT_EN adds the hazard_cnt observation port.
interface id_stage_pipe_if #(
    parameter int DATA_W     = 8,
    parameter int INST_W     = 8,
    parameter int REG_ADDR_W = 2
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     pc_in;
    logic [INST_W-1:0]     inst_in;
    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]     wb_data;
    logic                  ex_ready;
    logic                  flush;
    logic                  out_valid;
    logic [DATA_W-1:0]     pc_out;
    logic [DATA_W-1:0]     reg_val;
    logic [DATA_W-1:0]     ext_imm;
    logic [REG_ADDR_W-1:0] rd_out;
    logic [2:0]            funct_out;
    logic J, JC, INA, RM, WM, SIN, SOUT, WR_OUT, NEQ;
`ifdef ID_HAZARD_CNT_EN
    logic [15:0]           hazard_cnt;
`endif

    modport master (
        output in_valid, pc_in, inst_in, wb_we, wb_addr, wb_data, ex_ready, flush,
        input  in_ready, out_valid, pc_out, reg_val, ext_imm, rd_out, funct_out,
        input  J, JC, INA, RM, WM, SIN, SOUT, WR_OUT, NEQ
`ifdef ID_HAZARD_CNT_EN
        , input hazard_cnt
`endif
    );

    modport slave (
        input  in_valid, pc_in, inst_in, wb_we, wb_addr, wb_data, ex_ready, flush,
        output in_ready, out_valid, pc_out, reg_val, ext_imm, rd_out, funct_out,
        output J, JC, INA, RM, WM, SIN, SOUT, WR_OUT, NEQ
`ifdef ID_HAZARD_CNT_EN
        , output hazard_cnt
`endif
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage with register bank, write-back bypass, load-use bubbling and an ID/EX register.
// Define ID_HAZARD_CNT_EN to add a saturating 16-bit load-use stall counter.
module id_stage_pipe #(
    parameter int DATA_W     = 8,
    parameter int INST_W     = 8,
    parameter int REG_ADDR_W = 2
) (
    input logic          clock,
    input logic          reset,
    id_stage_pipe_if.slave bus
);
    localparam int IMM_W = INST_W - 3;
    localparam int NREGS = 2 ** REG_ADDR_W;

    typedef enum logic [2:0] {
        OP_ALU   = 3'b000,
        OP_LOAD  = 3'b001,
        OP_STORE = 3'b010,
        OP_IMM   = 3'b011,
        OP_J     = 3'b100,
        OP_JC    = 3'b101,
        OP_JNE   = 3'b110,
        OP_IO    = 3'b111
    } opcode_e;

    typedef struct packed {
        logic j, jc, ina, rm, wm, sin, sout, wr_out, neq;
    } ctrl_t;

    opcode_e               opcode;
    logic [REG_ADDR_W-1:0] r;
    logic [2:0]            funct;
    logic [IMM_W-1:0]      imm;
    logic [DATA_W-1:0]     imm_ext;
    logic [DATA_W-1:0]     r_val;
    ctrl_t                 ctrl_d;
    logic                  use_r;

    logic [DATA_W-1:0]     bank [NREGS];
    logic                  out_valid_q;
    logic [DATA_W-1:0]     pc_q, reg_val_q, ext_imm_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [2:0]            funct_q;
    ctrl_t                 ctrl_q;

    logic hazard, advance, accept;

    assign opcode  = opcode_e'(bus.inst_in[INST_W-1 -: 3]);
    assign r       = bus.inst_in[INST_W-4 -: REG_ADDR_W];
    assign funct   = bus.inst_in[2:0];
    assign imm     = bus.inst_in[IMM_W-1:0];
    assign imm_ext = DATA_W'($signed(imm));

    // Same-cycle write-back wins over the stored value.
    assign r_val = (bus.wb_we && bus.wb_addr == r) ? bus.wb_data : bank[r];

    // NOTE: defaults first so every path assigns every bit and no latch is inferred.
    always_comb begin
        ctrl_d = '0;
        use_r  = 1'b0;
        case (opcode)
            OP_ALU:   begin ctrl_d.wr_out = 1'b1; use_r = 1'b1; end
            OP_LOAD:  begin ctrl_d.rm = 1'b1; ctrl_d.wr_out = 1'b1; use_r = 1'b1; end
            OP_STORE: begin ctrl_d.wm = 1'b1; use_r = 1'b1; end
            OP_IMM:   begin ctrl_d.ina = 1'b1; ctrl_d.wr_out = 1'b1; end
            OP_J:     ctrl_d.j = 1'b1;
            OP_JC:    begin ctrl_d.jc = 1'b1; use_r = 1'b1; end
            OP_JNE:   begin ctrl_d.jc = 1'b1; ctrl_d.neq = 1'b1; use_r = 1'b1; end
            OP_IO: begin
                if (funct[0]) begin
                    ctrl_d.sout = 1'b1;
                    use_r       = 1'b1;
                end else begin
                    ctrl_d.sin    = 1'b1;
                    ctrl_d.wr_out = 1'b1;
                end
            end
        endcase
    end

    assign hazard       = out_valid_q & ctrl_q.rm & use_r & (rd_q == r) & bus.in_valid;
    assign advance      = ~out_valid_q | bus.ex_ready;
    assign accept       = advance & bus.in_valid & ~hazard;
    assign bus.in_ready = advance & ~hazard & ~bus.flush;

    // NOTE: non-blocking assignments for all state; the bank is cleared on reset because
    // software relies on registers reading zero after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) bank[i] <= '0;
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            reg_val_q   <= '0;
            ext_imm_q   <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            ctrl_q      <= '0;
        end else begin
            if (bus.wb_we) bank[bus.wb_addr] <= bus.wb_data;

            if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (accept) begin
                out_valid_q <= 1'b1;
                pc_q        <= bus.pc_in;
                reg_val_q   <= r_val;
                ext_imm_q   <= imm_ext;
                rd_q        <= r;
                funct_q     <= funct;
                ctrl_q      <= ctrl_d;
            end else if (advance) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.pc_out    = pc_q;
    assign bus.reg_val   = reg_val_q;
    assign bus.ext_imm   = ext_imm_q;
    assign bus.rd_out    = rd_q;
    assign bus.funct_out = funct_q;
    assign bus.J         = ctrl_q.j;
    assign bus.JC        = ctrl_q.jc;
    assign bus.INA       = ctrl_q.ina;
    assign bus.RM        = ctrl_q.rm;
    assign bus.WM        = ctrl_q.wm;
    assign bus.SIN       = ctrl_q.sin;
    assign bus.SOUT      = ctrl_q.sout;
    assign bus.WR_OUT    = ctrl_q.wr_out;
    assign bus.NEQ       = ctrl_q.neq;

`ifdef ID_HAZARD_CNT_EN
    logic [15:0] hazard_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hazard_cnt_q <= '0;
        end else if (advance && bus.in_valid && hazard && !bus.flush
                     && hazard_cnt_q != 16'hFFFF) begin
            hazard_cnt_q <= hazard_cnt_q + 16'd1;
        end
    end

    assign bus.hazard_cnt = hazard_cnt_q;
`endif
endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: scoreboard of decoded records plus directed scenarios.
// Checks hazard_cnt when ID_HAZARD_CNT_EN is defined.
module tb_id_stage_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    id_stage_pipe_if #(.DATA_W(8), .INST_W(8), .REG_ADDR_W(2)) bus ();

    id_stage_pipe #(.DATA_W(8), .INST_W(8), .REG_ADDR_W(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] reg_val;
        logic [7:0] ext_imm;
        logic [1:0] rd;
        logic [2:0] funct;
        logic [8:0] ctrl;   // {J,JC,INA,RM,WM,SIN,SOUT,WR_OUT,NEQ}
    } rec_t;

    rec_t       sb [$];
    logic [7:0] mbank [4];

    function automatic logic [8:0] exp_ctrl(input logic [7:0] inst);
        case (inst[7:5])
            3'd0: return 9'b000000010;
            3'd1: return 9'b000100010;
            3'd2: return 9'b000010000;
            3'd3: return 9'b001000010;
            3'd4: return 9'b100000000;
            3'd5: return 9'b010000000;
            3'd6: return 9'b010000001;
            default: return inst[0] ? 9'b000000100 : 9'b000001010;
        endcase
    endfunction

    function automatic logic [8:0] act_ctrl();
        return {bus.J, bus.JC, bus.INA, bus.RM, bus.WM, bus.SIN, bus.SOUT, bus.WR_OUT, bus.NEQ};
    endfunction

    // Reference register bank.
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mbank[i] <= 8'h00;
        end else if (bus.wb_we) begin
            mbank[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Scoreboard: push on acceptance, pop and compare when EX takes the output.
    always @(negedge clock) begin
        rec_t exp_r, act_r;
        logic [1:0] ra;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.ex_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: output pc=%h appeared, none expected", bus.pc_out);
                end else begin
                    exp_r = sb.pop_front();
                    act_r = '{bus.pc_out, bus.reg_val, bus.ext_imm, bus.rd_out, bus.funct_out, act_ctrl()};
                    if (act_r !== exp_r) begin
                        errors++;
                        $display("FAIL sb_record: got %h expected %h", act_r, exp_r);
                    end
                end
            end else if (bus.out_valid && bus.flush && sb.size() > 0) begin
                void'(sb.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                ra = bus.inst_in[4:3];
                exp_r.pc      = bus.pc_in;
                exp_r.reg_val = (bus.wb_we && bus.wb_addr == ra) ? bus.wb_data : mbank[ra];
                exp_r.ext_imm = {{3{bus.inst_in[4]}}, bus.inst_in[4:0]};
                exp_r.rd      = ra;
                exp_r.funct   = bus.inst_in[2:0];
                exp_r.ctrl    = exp_ctrl(bus.inst_in);
                sb.push_back(exp_r);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.pc_in    = 8'h00;
        bus.inst_in  = 8'h00;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 2'd0;
        bus.wb_data  = 8'h00;
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
    endtask

    task automatic present(input logic [7:0] pc, input logic [7:0] inst);
        bus.in_valid = 1'b1;
        bus.pc_in    = pc;
        bus.inst_in  = inst;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        present(8'hAA, 8'b001_01_111);
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.pc_out, bus.reg_val, bus.ext_imm, bus.rd_out, bus.funct_out, act_ctrl()} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: pc=%h reg=%h imm=%h ctrl=%b expected all 0",
                     bus.pc_out, bus.reg_val, bus.ext_imm, act_ctrl());
        end
    endtask

    task automatic test_alu();
        bus.wb_we = 1'b1; bus.wb_addr = 2'd1; bus.wb_data = 8'h5A;
        tick();
        idle();
        present(8'h10, 8'b000_01_011);
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.pc_out !== 8'h10 || bus.reg_val !== 8'h5A
            || bus.rd_out !== 2'd1 || bus.funct_out !== 3'd3 || act_ctrl() !== 9'b000000010) begin
            errors++;
            $display("FAIL alu: v=%b pc=%h reg=%h rd=%0d f=%0d ctrl=%b expected 1/10/5a/1/3/000000010",
                     bus.out_valid, bus.pc_out, bus.reg_val, bus.rd_out, bus.funct_out, act_ctrl());
        end
        tick();
    endtask

    task automatic test_imm();
        present(8'h20, 8'b011_10110);
        tick();
        present(8'h21, 8'b011_00101);
        checks++;
        if (bus.ext_imm !== 8'hF6 || bus.INA !== 1'b1 || bus.WR_OUT !== 1'b1) begin
            errors++;
            $display("FAIL imm_neg: ext_imm=%h INA=%b WR_OUT=%b expected f6/1/1", bus.ext_imm, bus.INA, bus.WR_OUT);
        end
        tick();
        idle();
        checks++;
        if (bus.ext_imm !== 8'h05 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL imm_pos: ext_imm=%h out_valid=%b expected 05/1", bus.ext_imm, bus.out_valid);
        end
        tick();
    endtask

    task automatic test_bypass();
        bus.wb_we = 1'b1; bus.wb_addr = 2'd2; bus.wb_data = 8'hC3;
        present(8'h30, 8'b000_10_000);
        tick();
        idle();
        present(8'h31, 8'b000_10_001);
        checks++;
        if (bus.reg_val !== 8'hC3) begin
            errors++;
            $display("FAIL bypass_same_cycle: reg_val=%h expected c3", bus.reg_val);
        end
        tick();
        idle();
        checks++;
        if (bus.reg_val !== 8'hC3 || bus.pc_out !== 8'h31) begin
            errors++;
            $display("FAIL bypass_stored: reg_val=%h pc=%h expected c3/31", bus.reg_val, bus.pc_out);
        end
        tick();
    endtask

    task automatic load_use_pair(input logic [7:0] pc);
        present(pc, 8'b001_01_000);
        tick();
        present(pc + 8'd1, 8'b000_01_010);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lu_stall: in_ready=%b expected 0", bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_bubble: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.pc_out !== pc + 8'd1) begin
            errors++;
            $display("FAIL lu_issue: out_valid=%b pc=%h expected 1/%h", bus.out_valid, bus.pc_out, pc + 8'd1);
        end
    endtask

    task automatic test_load_use();
        load_use_pair(8'h40);
        present(8'h42, 8'b000_10_000);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_indep_after: in_ready=%b expected 1", bus.in_ready);
        end
        tick();
        present(8'h43, 8'b001_01_000);
        tick();
        present(8'h44, 8'b000_10_000);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL lu_no_false_hazard: in_ready=%b expected 1", bus.in_ready);
        end
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.pc_out !== 8'h44) begin
            errors++;
            $display("FAIL lu_indep_issue: out_valid=%b pc=%h expected 1/44", bus.out_valid, bus.pc_out);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] insts [6] = '{8'b100_00000, 8'b101_11_000, 8'b110_01_111,
                                  8'b111_00_000, 8'b111_10_001, 8'b010_11_101};
        for (int i = 0; i < 6; i++) begin
            present(8'h80 + 8'(i), insts[i]);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.pc_out !== 8'h80 + 8'(i)) begin
                errors++;
                $display("FAIL b2b_%0d: out_valid=%b pc=%h expected 1/%h", i, bus.out_valid, bus.pc_out, 8'h80 + 8'(i));
            end
        end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        present(8'h50, 8'b000_11_000);
        tick();
        bus.ex_ready = 1'b0;
        present(8'h51, 8'b000_00_001);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.pc_out !== 8'h50) begin
                errors++;
                $display("FAIL bp_hold_%0d: in_ready=%b out_valid=%b pc=%h expected 0/1/50",
                         i, bus.in_ready, bus.out_valid, bus.pc_out);
            end
            tick();
        end
        bus.ex_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b expected 1", bus.in_ready);
        end
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.pc_out !== 8'h51) begin
            errors++;
            $display("FAIL bp_capture: out_valid=%b pc=%h expected 1/51", bus.out_valid, bus.pc_out);
        end
        tick();
    endtask

    task automatic test_flush();
        present(8'h60, 8'b000_01_000);
        tick();
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b1;
        present(8'h61, 8'b000_10_000);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready=%b expected 0", bus.in_ready);
        end
        tick();
        idle();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.pc_out !== 8'h60) begin
            errors++;
            $display("FAIL flush_kill: out_valid=%b pc=%h expected 0/60", bus.out_valid, bus.pc_out);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        present(8'h70, 8'b000_01_000);
        tick();
        bus.ex_ready = 1'b0;
        present(8'h71, 8'b000_10_000);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.pc_out !== 8'h00 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall: out_valid=%b pc=%h in_ready=%b expected 0/00/1",
                     bus.out_valid, bus.pc_out, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_hazard_cnt();
        load_use_pair(8'h90);
        load_use_pair(8'hA0);
        load_use_pair(8'hB0);
        idle();
        tick();
`ifdef ID_HAZARD_CNT_EN
        checks++;
        if (bus.hazard_cnt !== 16'd3) begin
            errors++;
            $display("FAIL hazard_cnt: got %0d expected 3", bus.hazard_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_alu();
        test_imm();
        test_bypass();
        test_load_use();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_hazard_cnt();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d records left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
